// File: rtl/despachante_aprovados_pkg.sv
// Shared definitions for the approved-node dispatcher.
//   estado_t  : controller states, in batch order.
//   slot_lsb  : bit offset of slot i inside a slot-packed evaluator bus.
package despachante_aprovados_pkg;

    localparam int ESTADO_W = 3;

    typedef enum logic [ESTADO_W-1:0] {
        IDLE      = 3'd0,
        ESPERA    = 3'd1,
        CAPTURA   = 3'd2,
        SELECIONA = 3'd3,
        ESCRITA   = 3'd4,
        ENVIO     = 3'd5,
        REMOVE    = 3'd6,
        ASSENTA   = 3'd7
    } estado_t;

    function automatic int slot_lsb(input int slot, input int width);
        return slot * width;
    endfunction

endpackage

// File: rtl/despachante_aprovados_seletor_prioridade.sv
// Lowest-set-bit priority selector.
//   i_req     : request vector, bit 0 has the highest priority.
//   o_idx     : index of the lowest set bit (0 when none is set).
//   o_nenhum  : 1 when no bit of i_req is set.
module despachante_aprovados_seletor_prioridade #(
    parameter int NUM_NA = 4,
    parameter int IDX_W  = 2
) (
    input  logic [NUM_NA-1:0] i_req,
    output logic [IDX_W-1:0]  o_idx,
    output logic              o_nenhum
);

    // Scan from the top down so the last hit is the lowest index.
    always_comb begin
        o_idx    = '0;
        o_nenhum = 1'b1;
        for (int i = NUM_NA - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx    = IDX_W'(i);
                o_nenhum = 1'b0;
            end
        end
    end

endmodule

// File: rtl/despachante_aprovados.sv
// Approved-node dispatcher: consumer side of the active-node evaluator.
// Once the evaluator settles it snapshots every approved slot, then for each
// approved node (lowest slot first) writes the predecessor memory and offers
// the node to the expansion unit over valid/ready. After the batch drains it
// pulses remover_aprovados_out; when nothing is active or approved it pulses
// da_fim_out.
//   clk, rst_n              : clock, asynchronous active-low reset
//   habilitar_in            : run enable (level)
//   aa_*_in                 : evaluator status and slot-packed node data
//   exp_ocioso_in/ready_in  : expansion unit idle / accepts a node
//   exp_valid/endereco/distancia_out : node offer
//   mem_wr_*_out            : predecessor memory write port
//   remover_aprovados_out   : one-cycle removal pulse to the evaluator
//   da_fim_out              : one-cycle end-of-search pulse
//   da_ocupado_out          : batch in progress
//   da_despachados_out      : nodes dispatched since leaving IDLE
module despachante_aprovados
    import despachante_aprovados_pkg::*;
#(
    parameter int NUM_NA          = 4,
    parameter int ADDR_WIDTH      = 5,
    parameter int DISTANCIA_WIDTH = 5,
    parameter int CONT_WIDTH      = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            habilitar_in,
    input  logic                            aa_pronto_in,
    input  logic                            aa_ocupado_in,
    input  logic                            aa_tem_ativo_in,
    input  logic [NUM_NA-1:0]               aa_aprovado_in,
    input  logic [ADDR_WIDTH*NUM_NA-1:0]      aa_endereco_in,
    input  logic [DISTANCIA_WIDTH*NUM_NA-1:0] aa_distancia_in,
    input  logic [ADDR_WIDTH*NUM_NA-1:0]      aa_anterior_data_in,
    input  logic                            exp_ocioso_in,
    input  logic                            exp_ready_in,
    output logic                            exp_valid_out,
    output logic [ADDR_WIDTH-1:0]           exp_endereco_out,
    output logic [DISTANCIA_WIDTH-1:0]      exp_distancia_out,
    output logic                            mem_wr_en_out,
    output logic [ADDR_WIDTH-1:0]           mem_wr_addr_out,
    output logic [ADDR_WIDTH-1:0]           mem_wr_data_out,
    output logic                            remover_aprovados_out,
    output logic                            da_fim_out,
    output logic                            da_ocupado_out,
    output logic [CONT_WIDTH-1:0]           da_despachados_out
);

    localparam int IDX_W = (NUM_NA > 1) ? $clog2(NUM_NA) : 1;

    estado_t                    r_estado;
    estado_t                    w_prox;
    logic [NUM_NA-1:0]          r_pend;
    logic [IDX_W-1:0]           r_idx;
    logic [IDX_W-1:0]           w_sel_idx;
    logic                       w_sel_nenhum;
    logic                       w_handshake;
    logic                       w_fim;

    logic [ADDR_WIDTH-1:0]      r_snap_end  [NUM_NA];
    logic [DISTANCIA_WIDTH-1:0] r_snap_dist [NUM_NA];
    logic [ADDR_WIDTH-1:0]      r_snap_ant  [NUM_NA];

    logic                       r_exp_valid;
    logic                       r_mem_wr_en;
    logic [ADDR_WIDTH-1:0]      r_mem_wr_addr;
    logic [ADDR_WIDTH-1:0]      r_mem_wr_data;
    logic                       r_remover;
    logic                       r_fim;
    logic                       r_ocupado;
    logic [CONT_WIDTH-1:0]      r_cont;

    despachante_aprovados_seletor_prioridade #(
        .NUM_NA (NUM_NA),
        .IDX_W  (IDX_W)
    ) u_seletor (
        .i_req    (r_pend),
        .o_idx    (w_sel_idx),
        .o_nenhum (w_sel_nenhum)
    );

    assign w_handshake = r_exp_valid & exp_ready_in;

    // Exhaustion: settled evaluator with nothing approved and nothing active.
    assign w_fim = (r_estado == ESPERA) && habilitar_in && aa_pronto_in &&
                   !aa_ocupado_in && exp_ocioso_in &&
                   !(|aa_aprovado_in) && !aa_tem_ativo_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_estado <= IDLE;
        else        r_estado <= w_prox;
    end

    // habilitar_in is only sampled in IDLE/ESPERA, so a started batch always
    // runs to its removal pulse.
    always_comb begin
        w_prox = r_estado;
        case (r_estado)
            IDLE:      if (habilitar_in) w_prox = ESPERA;
            ESPERA: begin
                if (!habilitar_in) begin
                    w_prox = IDLE;
                end else if (aa_pronto_in && !aa_ocupado_in && exp_ocioso_in) begin
                    if (|aa_aprovado_in)       w_prox = CAPTURA;
                    else if (!aa_tem_ativo_in) w_prox = IDLE;
                end
            end
            CAPTURA:   w_prox = SELECIONA;
            SELECIONA: w_prox = w_sel_nenhum ? REMOVE : ESCRITA;
            ESCRITA:   w_prox = ENVIO;
            ENVIO:     if (w_handshake) w_prox = SELECIONA;
            REMOVE:    w_prox = ASSENTA;
            ASSENTA:   w_prox = ESPERA;
            default:   w_prox = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the
    // state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend        <= '0;
            r_idx         <= '0;
            r_cont        <= '0;
            r_exp_valid   <= 1'b0;
            r_mem_wr_en   <= 1'b0;
            r_mem_wr_addr <= '0;
            r_mem_wr_data <= '0;
            r_remover     <= 1'b0;
            r_fim         <= 1'b0;
            r_ocupado     <= 1'b0;
            for (int i = 0; i < NUM_NA; i++) begin
                r_snap_end[i]  <= '0;
                r_snap_dist[i] <= '0;
                r_snap_ant[i]  <= '0;
            end
        end else begin
            if (r_estado == IDLE && habilitar_in) begin
                r_cont <= '0;
            end

            // Snapshot decouples the batch from later evaluator updates.
            if (r_estado == CAPTURA) begin
                r_pend <= aa_aprovado_in;
                for (int i = 0; i < NUM_NA; i++) begin
                    r_snap_end[i]  <= aa_endereco_in[slot_lsb(i, ADDR_WIDTH) +: ADDR_WIDTH];
                    r_snap_dist[i] <= aa_distancia_in[slot_lsb(i, DISTANCIA_WIDTH) +: DISTANCIA_WIDTH];
                    r_snap_ant[i]  <= aa_anterior_data_in[slot_lsb(i, ADDR_WIDTH) +: ADDR_WIDTH];
                end
            end

            if (r_estado == SELECIONA && !w_sel_nenhum) begin
                r_idx <= w_sel_idx;
            end

            if (r_estado == ENVIO && w_handshake) begin
                r_pend[r_idx] <= 1'b0;
                r_cont        <= r_cont + CONT_WIDTH'(1);
            end

            // Entering ESCRITA always comes from SELECIONA, where the
            // selector output is the index being latched.
            if (w_prox == ESCRITA) begin
                r_mem_wr_addr <= r_snap_end[w_sel_idx];
                r_mem_wr_data <= r_snap_ant[w_sel_idx];
            end

            r_mem_wr_en <= (w_prox == ESCRITA);
            r_exp_valid <= (w_prox == ENVIO);
            r_remover   <= (w_prox == REMOVE);
            r_fim       <= w_fim;
            r_ocupado   <= !(w_prox == IDLE || w_prox == ESPERA);
        end
    end

    assign exp_valid_out         = r_exp_valid;
    assign exp_endereco_out      = r_snap_end[r_idx];
    assign exp_distancia_out     = r_snap_dist[r_idx];
    assign mem_wr_en_out         = r_mem_wr_en;
    assign mem_wr_addr_out       = r_mem_wr_addr;
    assign mem_wr_data_out       = r_mem_wr_data;
    assign remover_aprovados_out = r_remover;
    assign da_fim_out            = r_fim;
    assign da_ocupado_out        = r_ocupado;
    assign da_despachados_out    = r_cont;

endmodule

// File: tb/tb_despachante_aprovados.sv
module tb_despachante_aprovados;

    localparam int NUM_NA = 4;
    localparam int AW     = 5;
    localparam int DW     = 5;
    localparam int CW     = 16;

    logic                 clk;
    logic                 rst_n;
    logic                 habilitar_in;
    logic                 aa_pronto_in;
    logic                 aa_ocupado_in;
    logic                 aa_tem_ativo_in;
    logic [NUM_NA-1:0]    aa_aprovado_in;
    logic [AW*NUM_NA-1:0] aa_endereco_in;
    logic [DW*NUM_NA-1:0] aa_distancia_in;
    logic [AW*NUM_NA-1:0] aa_anterior_data_in;
    logic                 exp_ocioso_in;
    logic                 exp_ready_in;
    logic                 exp_valid_out;
    logic [AW-1:0]        exp_endereco_out;
    logic [DW-1:0]        exp_distancia_out;
    logic                 mem_wr_en_out;
    logic [AW-1:0]        mem_wr_addr_out;
    logic [AW-1:0]        mem_wr_data_out;
    logic                 remover_aprovados_out;
    logic                 da_fim_out;
    logic                 da_ocupado_out;
    logic [CW-1:0]        da_despachados_out;

    despachante_aprovados #(
        .NUM_NA(NUM_NA), .ADDR_WIDTH(AW), .DISTANCIA_WIDTH(DW), .CONT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .habilitar_in(habilitar_in),
        .aa_pronto_in(aa_pronto_in), .aa_ocupado_in(aa_ocupado_in),
        .aa_tem_ativo_in(aa_tem_ativo_in), .aa_aprovado_in(aa_aprovado_in),
        .aa_endereco_in(aa_endereco_in), .aa_distancia_in(aa_distancia_in),
        .aa_anterior_data_in(aa_anterior_data_in),
        .exp_ocioso_in(exp_ocioso_in), .exp_ready_in(exp_ready_in),
        .exp_valid_out(exp_valid_out), .exp_endereco_out(exp_endereco_out),
        .exp_distancia_out(exp_distancia_out), .mem_wr_en_out(mem_wr_en_out),
        .mem_wr_addr_out(mem_wr_addr_out), .mem_wr_data_out(mem_wr_data_out),
        .remover_aprovados_out(remover_aprovados_out), .da_fim_out(da_fim_out),
        .da_ocupado_out(da_ocupado_out), .da_despachados_out(da_despachados_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Evaluator slot contents as the bench currently presents them.
    logic [AW-1:0] m_end [NUM_NA];
    logic [AW-1:0] m_ant [NUM_NA];
    logic [DW-1:0] m_dist[NUM_NA];

    // Observed traffic and expected traffic, {address, predecessor|distance}.
    logic [AW+AW-1:0] q_wr[$];
    logic [AW+DW-1:0] q_hs[$];
    logic [AW+AW-1:0] e_wr[$];
    logic [AW+DW-1:0] e_hs[$];
    int rem_cnt;
    int fim_cnt;
    int exp_cnt;

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_wr_en_out) q_wr.push_back({mem_wr_addr_out, mem_wr_data_out});
            if (exp_valid_out && exp_ready_in) q_hs.push_back({exp_endereco_out, exp_distancia_out});
            if (remover_aprovados_out) rem_cnt++;
            if (da_fim_out) fim_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pack_inputs();
        for (int i = 0; i < NUM_NA; i++) begin
            aa_endereco_in[i*AW +: AW]      = m_end[i];
            aa_anterior_data_in[i*AW +: AW] = m_ant[i];
            aa_distancia_in[i*DW +: DW]     = m_dist[i];
        end
    endtask

    task automatic clr_log();
        q_wr.delete();
        q_hs.delete();
        rem_cnt = 0;
        fim_cnt = 0;
    endtask

    // Reference: each approved slot, lowest index first, is written then sent.
    task automatic model_batch(input logic [NUM_NA-1:0] apr);
        e_wr.delete();
        e_hs.delete();
        for (int i = 0; i < NUM_NA; i++) begin
            if (apr[i]) begin
                e_wr.push_back({m_end[i], m_ant[i]});
                e_hs.push_back({m_end[i], m_dist[i]});
            end
        end
    endtask

    // Drives ready until the removal pulse, then acts as the evaluator and
    // drops the approved flags. to = 1 if the pulse never came.
    task automatic run_batch(input bit rnd_ready, output bit to);
        to = 1'b1;
        for (int c = 0; c < 500; c++) begin
            step();
            if (remover_aprovados_out) begin
                to = 1'b0;
                break;
            end
            exp_ready_in = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        aa_aprovado_in = '0;
        repeat (3) step();
    endtask

    task automatic wait_valid(output bit to);
        to = 1'b1;
        for (int c = 0; c < 30; c++) begin
            step();
            if (exp_valid_out) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic enable_search();
        habilitar_in = 1'b0;
        step();
        habilitar_in = 1'b1;
        step();
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        aa_aprovado_in = 4'b1111;
        habilitar_in = 1'b1;
        step();
        step();
        checks++;
        if ({exp_valid_out, exp_endereco_out, exp_distancia_out, mem_wr_en_out,
             mem_wr_addr_out, mem_wr_data_out, remover_aprovados_out, da_fim_out,
             da_ocupado_out, da_despachados_out} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got nonzero: valid=%0b wr=%0b rem=%0b fim=%0b oc=%0b cnt=%0d, required all 0",
                     exp_valid_out, mem_wr_en_out, remover_aprovados_out, da_fim_out,
                     da_ocupado_out, da_despachados_out);
        end
        habilitar_in = 1'b0;
        aa_aprovado_in = '0;
        rst_n = 1'b1;
        step();
        step();
        checks++;
        if (da_ocupado_out !== 1'b0 || exp_valid_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle oc=%0b valid=%0b, required 0 0", da_ocupado_out, exp_valid_out);
        end
    endtask

    task automatic test_basic();
        bit to;
        m_end[0] = 5'd3;  m_end[1] = 5'd9;  m_end[2] = 5'd12; m_end[3] = 5'd7;
        m_ant[0] = 5'd1;  m_ant[1] = 5'd2;  m_ant[2] = 5'd3;  m_ant[3] = 5'd4;
        m_dist[0] = 5'd10; m_dist[1] = 5'd11; m_dist[2] = 5'd12; m_dist[3] = 5'd13;
        pack_inputs();
        enable_search();
        checks++;
        if (da_despachados_out !== 16'd0) begin
            errors++;
            $display("FAIL basic_cnt_start got %0d required 0", da_despachados_out);
        end
        clr_log();
        exp_ready_in = 1'b1;
        model_batch(4'b1010);
        aa_aprovado_in = 4'b1010;
        run_batch(1'b0, to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL basic_timeout no remover pulse, required one");
        end
        checks++;
        if (q_wr.size() != e_wr.size() || q_hs.size() != e_hs.size()) begin
            errors++;
            $display("FAIL basic_len wr %0d hs %0d, required %0d %0d", q_wr.size(), q_hs.size(), e_wr.size(), e_hs.size());
        end else begin
            for (int k = 0; k < e_wr.size(); k++) begin
                checks++;
                if (q_wr[k] !== e_wr[k] || q_hs[k] !== e_hs[k]) begin
                    errors++;
                    $display("FAIL basic_item%0d wr %h hs %h, required %h %h", k, q_wr[k], q_hs[k], e_wr[k], e_hs[k]);
                end
            end
        end
        checks++;
        if (rem_cnt != 1 || fim_cnt != 0) begin
            errors++;
            $display("FAIL basic_pulses rem %0d fim %0d, required 1 0", rem_cnt, fim_cnt);
        end
        exp_cnt = 2;
        checks++;
        if (da_despachados_out !== 16'(exp_cnt) || da_ocupado_out !== 1'b0) begin
            errors++;
            $display("FAIL basic_cnt got %0d oc %0b, required %0d 0", da_despachados_out, da_ocupado_out, exp_cnt);
        end
    endtask

    task automatic test_backpressure();
        bit to;
        clr_log();
        exp_ready_in = 1'b0;
        model_batch(4'b1010);
        aa_aprovado_in = 4'b1010;
        wait_valid(to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL bp_valid_timeout valid never rose, required 1");
        end
        for (int c = 0; c < 5; c++) begin
            step();
            checks++;
            if (exp_valid_out !== 1'b1 || exp_endereco_out !== m_end[1] || exp_distancia_out !== m_dist[1]) begin
                errors++;
                $display("FAIL bp_hold%0d valid %0b addr %0d dist %0d, required 1 %0d %0d", c,
                         exp_valid_out, exp_endereco_out, exp_distancia_out, m_end[1], m_dist[1]);
            end
        end
        checks++;
        if (q_wr.size() != 1 || q_hs.size() != 0) begin
            errors++;
            $display("FAIL bp_stall wr %0d hs %0d, required 1 0", q_wr.size(), q_hs.size());
        end
        exp_ready_in = 1'b1;
        run_batch(1'b0, to);
        checks++;
        if (to || q_wr.size() != e_wr.size() || q_hs.size() != e_hs.size()) begin
            errors++;
            $display("FAIL bp_len to %0b wr %0d hs %0d, required 0 %0d %0d", to, q_wr.size(), q_hs.size(), e_wr.size(), e_hs.size());
        end else begin
            for (int k = 0; k < e_wr.size(); k++) begin
                checks++;
                if (q_wr[k] !== e_wr[k] || q_hs[k] !== e_hs[k]) begin
                    errors++;
                    $display("FAIL bp_item%0d wr %h hs %h, required %h %h", k, q_wr[k], q_hs[k], e_wr[k], e_hs[k]);
                end
            end
        end
        exp_cnt += 2;
        checks++;
        if (da_despachados_out !== 16'(exp_cnt) || rem_cnt != 1) begin
            errors++;
            $display("FAIL bp_cnt got %0d rem %0d, required %0d 1", da_despachados_out, rem_cnt, exp_cnt);
        end
    endtask

    task automatic test_snapshot();
        bit to;
        clr_log();
        exp_ready_in = 1'b0;
        model_batch(4'b1010);
        aa_aprovado_in = 4'b1010;
        wait_valid(to);
        m_end[3] = 5'd30;
        m_ant[3] = 5'd31;
        m_dist[3] = 5'd29;
        pack_inputs();
        exp_ready_in = 1'b1;
        run_batch(1'b0, to);
        checks++;
        if (to || q_hs.size() != 2 || q_wr.size() != 2) begin
            errors++;
            $display("FAIL snap_len to %0b wr %0d hs %0d, required 0 2 2", to, q_wr.size(), q_hs.size());
        end else begin
            checks++;
            if (q_hs[1] !== e_hs[1] || q_wr[1] !== e_wr[1]) begin
                errors++;
                $display("FAIL snap_second hs %h wr %h, required %h %h", q_hs[1], q_wr[1], e_hs[1], e_wr[1]);
            end
        end
        m_end[3] = 5'd7;
        m_ant[3] = 5'd4;
        m_dist[3] = 5'd13;
        pack_inputs();
        exp_cnt += 2;
    endtask

    task automatic test_exhaustion();
        bit seen;
        clr_log();
        seen = 1'b0;
        aa_aprovado_in = '0;
        aa_tem_ativo_in = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (da_fim_out) begin
                seen = 1'b1;
                break;
            end
        end
        habilitar_in = 1'b0;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL fim_timeout da_fim never pulsed, required one pulse");
        end
        step();
        checks++;
        if (da_fim_out !== 1'b0 || da_ocupado_out !== 1'b0) begin
            errors++;
            $display("FAIL fim_width fim %0b oc %0b, required 0 0", da_fim_out, da_ocupado_out);
        end
        repeat (5) step();
        checks++;
        if (fim_cnt != 1 || rem_cnt != 0) begin
            errors++;
            $display("FAIL fim_count fim %0d rem %0d, required 1 0", fim_cnt, rem_cnt);
        end
        aa_tem_ativo_in = 1'b1;
    endtask

    task automatic test_gating();
        bit to;
        enable_search();
        checks++;
        if (da_despachados_out !== 16'd0) begin
            errors++;
            $display("FAIL gate_cnt_clear got %0d required 0", da_despachados_out);
        end
        clr_log();
        exp_ocioso_in = 1'b0;
        aa_aprovado_in = 4'b0001;
        repeat (8) step();
        checks++;
        if (q_wr.size() != 0 || da_ocupado_out !== 1'b0) begin
            errors++;
            $display("FAIL gate_ocioso wr %0d oc %0b, required 0 0", q_wr.size(), da_ocupado_out);
        end
        exp_ocioso_in = 1'b1;
        aa_ocupado_in = 1'b1;
        repeat (8) step();
        checks++;
        if (q_wr.size() != 0 || da_ocupado_out !== 1'b0) begin
            errors++;
            $display("FAIL gate_ocupado wr %0d oc %0b, required 0 0", q_wr.size(), da_ocupado_out);
        end
        aa_ocupado_in = 1'b0;
        exp_ready_in = 1'b1;
        model_batch(4'b0001);
        run_batch(1'b0, to);
        checks++;
        if (to || q_wr.size() != 1 || q_hs.size() != 1) begin
            errors++;
            $display("FAIL gate_release to %0b wr %0d hs %0d, required 0 1 1", to, q_wr.size(), q_hs.size());
        end else begin
            checks++;
            if (q_wr[0] !== e_wr[0] || q_hs[0] !== e_hs[0]) begin
                errors++;
                $display("FAIL gate_item wr %h hs %h, required %h %h", q_wr[0], q_hs[0], e_wr[0], e_hs[0]);
            end
        end
        exp_cnt = 1;
    endtask

    task automatic test_random();
        bit to;
        logic [NUM_NA-1:0] apr;
        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < NUM_NA; i++) begin
                m_end[i]  = AW'($urandom_range(0, 31));
                m_ant[i]  = AW'($urandom_range(0, 31));
                m_dist[i] = DW'($urandom_range(0, 31));
            end
            pack_inputs();
            apr = NUM_NA'($urandom_range(1, 15));
            model_batch(apr);
            clr_log();
            exp_ready_in = 1'($urandom_range(0, 1));
            aa_aprovado_in = apr;
            run_batch(1'b1, to);
            exp_cnt += $countones(apr);
            checks++;
            if (to || q_wr.size() != e_wr.size() || q_hs.size() != e_hs.size() || rem_cnt != 1) begin
                errors++;
                $display("FAIL rand%0d_len to %0b wr %0d hs %0d rem %0d, required 0 %0d %0d 1", n, to,
                         q_wr.size(), q_hs.size(), rem_cnt, e_wr.size(), e_hs.size());
            end else begin
                for (int k = 0; k < e_wr.size(); k++) begin
                    checks++;
                    if (q_wr[k] !== e_wr[k] || q_hs[k] !== e_hs[k]) begin
                        errors++;
                        $display("FAIL rand%0d_item%0d wr %h hs %h, required %h %h", n, k, q_wr[k], q_hs[k], e_wr[k], e_hs[k]);
                    end
                end
            end
            checks++;
            if (da_despachados_out !== 16'(exp_cnt)) begin
                errors++;
                $display("FAIL rand%0d_cnt got %0d required %0d", n, da_despachados_out, exp_cnt);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        clr_log();
        exp_ready_in = 1'b0;
        aa_aprovado_in = 4'b0110;
        wait_valid(to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL rmid_valid_timeout valid never rose, required 1");
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({exp_valid_out, exp_endereco_out, exp_distancia_out, mem_wr_en_out,
             mem_wr_addr_out, mem_wr_data_out, remover_aprovados_out, da_fim_out,
             da_ocupado_out, da_despachados_out} !== '0) begin
            errors++;
            $display("FAIL rmid_outputs valid=%0b addr=%0d oc=%0b cnt=%0d, required all 0",
                     exp_valid_out, exp_endereco_out, da_ocupado_out, da_despachados_out);
        end
        habilitar_in = 1'b0;
        aa_aprovado_in = '0;
        exp_ready_in = 1'b1;
        step();
        step();
        rst_n = 1'b1;
        repeat (10) step();
        checks++;
        if (rem_cnt != 0 || q_hs.size() != 0 || da_ocupado_out !== 1'b0) begin
            errors++;
            $display("FAIL rmid_after rem %0d hs %0d oc %0b, required 0 0 0", rem_cnt, q_hs.size(), da_ocupado_out);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        habilitar_in = 1'b0;
        aa_pronto_in = 1'b1;
        aa_ocupado_in = 1'b0;
        aa_tem_ativo_in = 1'b1;
        aa_aprovado_in = '0;
        aa_endereco_in = '0;
        aa_distancia_in = '0;
        aa_anterior_data_in = '0;
        exp_ocioso_in = 1'b1;
        exp_ready_in = 1'b0;
        rem_cnt = 0;
        fim_cnt = 0;
        exp_cnt = 0;
        test_reset();
        test_basic();
        test_backpressure();
        test_snapshot();
        test_exhaustion();
        test_gating();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
